// File: rtl/glyph_line_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : glyph_line_scheduler_if
//  Purpose  : Video timing, sprite-table config, glyph ROM and render
//             signals of the per-scanline glyph sprite scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface glyph_line_scheduler_if;
    // Video timing
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       fetch_start;
    logic       line_begin;

    // Sprite table write port
    logic       cfg_we;
    logic [3:0] cfg_idx;
    logic       cfg_en;
    logic [9:0] cfg_x;
    logic [9:0] cfg_y;
    logic [3:0] cfg_glyph;

    // Shared glyph ROM
    logic [6:0] rom_addr;
    logic [7:0] rom_data;

    // Render and status
    logic       pixel_on;
    logic [3:0] pixel_id;
    logic       busy;
    logic       overflow;
    logic       late;

    // Driver side: video timing, configuration and ROM
    modport master (
        output hpos, vpos, fetch_start, line_begin,
        output cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_glyph,
        output rom_data,
        input  rom_addr, pixel_on, pixel_id, busy, overflow, late
    );

    // Scheduler side
    modport slave (
        input  hpos, vpos, fetch_start, line_begin,
        input  cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_glyph,
        input  rom_data,
        output rom_addr, pixel_on, pixel_id, busy, overflow, late
    );
endinterface
`default_nettype wire

// File: rtl/glyph_line_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : glyph_line_scheduler
//  Purpose  : Per-scanline sprite scheduler. Scans the sprite table during
//             hblank, fetches each hit's glyph row into a back line buffer,
//             and renders from the front buffer during the visible line.
//  Revision : 1.0  initial release
// ============================================================================
module glyph_line_scheduler #(
    parameter int NSPR        = 12,
    parameter int SLOTS       = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int V_LINES     = 525
) (
    input wire clk,
    input wire rst_n,
    glyph_line_scheduler_if.slave bus
);

    // Sprite edge length in pixels, kept in 11 bits so edge compares never wrap
    localparam logic [10:0] c_SPR_SIZE = 11'(8 << SCALE_SHIFT);
    // Slot counter must be able to hold SLOTS itself (the "full" value)
    localparam int          CW         = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Sprite table
    // ------------------------------------------------------------------
    logic       r_tab_en    [NSPR];
    logic [9:0] r_tab_x     [NSPR];
    logic [9:0] r_tab_y     [NSPR];
    logic [3:0] r_tab_glyph [NSPR];

    // ------------------------------------------------------------------
    // Scheduler state
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [9:0]      r_ty;
    logic [3:0]      r_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_cap_pend;
    logic [CW-1:0]   r_cap_slot;
    logic [6:0]      r_rom_addr;
    logic            r_overflow;
    logic            r_late;

    // Back (being filled) and front (being rendered) line buffers
    logic            r_bk_valid [SLOTS];
    logic [9:0]      r_bk_x     [SLOTS];
    logic [3:0]      r_bk_id    [SLOTS];
    logic [7:0]      r_bk_row   [SLOTS];
    logic            r_fr_valid [SLOTS];
    logic [9:0]      r_fr_x     [SLOTS];
    logic [3:0]      r_fr_id    [SLOTS];
    logic [7:0]      r_fr_row   [SLOTS];

    // Registered render outputs
    logic            r_pix_on;
    logic [3:0]      r_pix_id;

    // ------------------------------------------------------------------
    // Combinational scan datapath
    // ------------------------------------------------------------------
    logic            w_sel_en;
    logic [9:0]      w_sel_x;
    logic [9:0]      w_sel_y;
    logic [3:0]      w_sel_glyph;
    logic [10:0]     w_ty11;
    logic [10:0]     w_y11;
    logic [10:0]     w_dy;
    logic [2:0]      w_row;
    logic            w_hit;
    logic            w_issue;
    logic [6:0]      w_rom_req;
    logic            w_swap;
    logic            w_slot_px  [SLOTS];
    logic            w_pix_on;
    logic [3:0]      w_pix_id;

    // Table write port; out-of-range indices are silently dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSPR; i++) begin
                r_tab_en[i]    <= 1'b0;
                r_tab_x[i]     <= '0;
                r_tab_y[i]     <= '0;
                r_tab_glyph[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            for (int i = 0; i < NSPR; i++) begin
                if (bus.cfg_idx == 4'(i)) begin
                    r_tab_en[i]    <= bus.cfg_en;
                    r_tab_x[i]     <= bus.cfg_x;
                    r_tab_y[i]     <= bus.cfg_y;
                    r_tab_glyph[i] <= bus.cfg_glyph;
                end
            end
        end
    end

    // Read the table entry currently being scanned
    always_comb begin
        w_sel_en    = 1'b0;
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_sel_glyph = '0;
        for (int i = 0; i < NSPR; i++) begin
            if (r_idx == 4'(i)) begin
                w_sel_en    = r_tab_en[i];
                w_sel_x     = r_tab_x[i];
                w_sel_y     = r_tab_y[i];
                w_sel_glyph = r_tab_glyph[i];
            end
        end
    end

    // Vertical hit test and glyph row selection for the scanned entry
    assign w_ty11    = {1'b0, r_ty};
    assign w_y11     = {1'b0, w_sel_y};
    assign w_dy      = w_ty11 - w_y11;
    assign w_row     = 3'(w_dy >> SCALE_SHIFT);
    assign w_hit     = (r_state == S_SCAN) && w_sel_en &&
                       (w_ty11 >= w_y11) && (w_ty11 < (w_y11 + c_SPR_SIZE));
    assign w_issue   = w_hit && (r_cnt < CW'(SLOTS));
    assign w_rom_req = {w_sel_glyph, w_row};

    // A line boundary outside IDLE always publishes the back buffer
    assign w_swap    = bus.line_begin && (r_state != S_IDLE);

    // Scan FSM with line-buffer fill, ROM capture and buffer swap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ty       <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_cap_pend <= 1'b0;
            r_cap_slot <= '0;
            r_rom_addr <= '0;
            r_overflow <= 1'b0;
            r_late     <= 1'b0;
            for (int k = 0; k < SLOTS; k++) begin
                r_bk_valid[k] <= 1'b0;
                r_bk_x[k]     <= '0;
                r_bk_id[k]    <= '0;
                r_bk_row[k]   <= '0;
                r_fr_valid[k] <= 1'b0;
                r_fr_x[k]     <= '0;
                r_fr_id[k]    <= '0;
                r_fr_row[k]   <= '0;
            end
        end else begin
            r_cap_pend <= 1'b0;

            // ROM byte for last cycle's request; dropped if the line ends now
            if (r_cap_pend && !bus.line_begin &&
                (r_state == S_SCAN || r_state == S_DRAIN)) begin
                for (int k = 0; k < SLOTS; k++) begin
                    if (r_cap_slot == CW'(k)) begin
                        r_bk_row[k]   <= bus.rom_data;
                        r_bk_valid[k] <= 1'b1;
                    end
                end
            end

            if (w_issue) begin
                r_rom_addr <= w_rom_req;
            end

            if (w_swap) begin
                for (int k = 0; k < SLOTS; k++) begin
                    r_fr_valid[k] <= r_bk_valid[k];
                    r_fr_x[k]     <= r_bk_x[k];
                    r_fr_id[k]    <= r_bk_id[k];
                    r_fr_row[k]   <= r_bk_row[k];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.fetch_start) begin
                        r_ty  <= (bus.vpos == 10'(V_LINES - 1)) ? 10'd0 : bus.vpos + 10'd1;
                        r_idx <= '0;
                        r_cnt <= '0;
                        for (int k = 0; k < SLOTS; k++) begin
                            r_bk_valid[k] <= 1'b0;
                        end
                        r_state <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (w_hit) begin
                        if (w_issue) begin
                            for (int k = 0; k < SLOTS; k++) begin
                                if (r_cnt == CW'(k)) begin
                                    r_bk_x[k]  <= w_sel_x;
                                    r_bk_id[k] <= r_idx;
                                end
                            end
                            r_cap_slot <= r_cnt;
                            r_cap_pend <= !bus.line_begin;
                            r_cnt      <= r_cnt + CW'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    if (bus.line_begin) begin
                        r_late  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_idx == 4'(NSPR - 1)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end

                S_DRAIN: begin
                    if (bus.line_begin) begin
                        r_late  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (bus.line_begin) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Per-slot horizontal hit test and pixel bit lookup
    generate
        for (genvar k = 0; k < SLOTS; k++) begin : g_render
            logic [10:0] w_h11;
            logic [10:0] w_x11;
            logic [10:0] w_dx;
            logic [2:0]  w_col;
            assign w_h11 = {1'b0, bus.hpos};
            assign w_x11 = {1'b0, r_fr_x[k]};
            assign w_dx  = w_h11 - w_x11;
            assign w_col = 3'(w_dx >> SCALE_SHIFT);
            assign w_slot_px[k] = r_fr_valid[k] && (w_h11 >= w_x11) &&
                                  (w_h11 < (w_x11 + c_SPR_SIZE)) &&
                                  r_fr_row[k][3'd7 - w_col];
        end
    endgenerate

    // Lowest slot with a set pixel wins (slots are filled in sprite order)
    always_comb begin
        w_pix_on = 1'b0;
        w_pix_id = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (w_slot_px[k]) begin
                w_pix_on = 1'b1;
                w_pix_id = r_fr_id[k];
            end
        end
    end

    // Register the render result one cycle after hpos
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix_on <= 1'b0;
            r_pix_id <= '0;
        end else begin
            r_pix_on <= w_pix_on;
            r_pix_id <= w_pix_id;
        end
    end

    // rom_addr shows the live request while issuing, else the last one sent
    assign bus.rom_addr = w_issue ? w_rom_req : r_rom_addr;
    assign bus.pixel_on = r_pix_on;
    assign bus.pixel_id = r_pix_id;
    assign bus.busy     = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign bus.overflow = r_overflow;
    assign bus.late     = r_late;

endmodule
`default_nettype wire

// File: tb/tb_glyph_line_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glyph_line_scheduler
//  Purpose  : Self-checking bench for glyph_line_scheduler: directed
//             scenarios plus randomized sprite tables against a behavioural
//             line model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_glyph_line_scheduler;
    localparam int NSPR        = 12;
    localparam int SLOTS       = 4;
    localparam int SCALE_SHIFT = 1;
    localparam int V_LINES     = 525;
    localparam int SZ          = 8 << SCALE_SHIFT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    glyph_line_scheduler_if bus ();

    glyph_line_scheduler #(
        .NSPR(NSPR), .SLOTS(SLOTS), .SCALE_SHIFT(SCALE_SHIFT), .V_LINES(V_LINES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Glyph ROM: data valid one cycle after the address
    logic [7:0] rom [128];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // Reference model: sprite table, rendered sprite list, sticky flags
    logic       m_en  [NSPR];
    int         m_x   [NSPR];
    int         m_y   [NSPR];
    int         m_g   [NSPR];
    int         f_n;
    int         f_x   [SLOTS];
    int         f_id  [SLOTS];
    logic [7:0] f_row [SLOTS];
    logic       exp_ovf;
    logic       exp_late;
    logic [6:0] exp_rom;
    int         rom_chg;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NSPR; i++) m_en[i] = 1'b0;
        f_n      = 0;
        exp_ovf  = 1'b0;
        exp_late = 1'b0;
        exp_rom  = 7'd0;
    endfunction

    function automatic void exp_pix(input int h, output logic on, output logic [3:0] id);
        int b;
        on = 1'b0;
        id = 4'd0;
        for (int s = 0; s < f_n; s++) begin
            if (!on && h >= f_x[s] && h < f_x[s] + SZ) begin
                b = (h - f_x[s]) >> SCALE_SHIFT;
                if (f_row[s][7 - b]) begin
                    on = 1'b1;
                    id = 4'(f_id[s]);
                end
            end
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        check_eq("rst pixel_on", bus.pixel_on, 0);
        check_eq("rst pixel_id", bus.pixel_id, 0);
        check_eq("rst rom_addr", bus.rom_addr, 0);
        check_eq("rst busy",     bus.busy,     0);
        check_eq("rst overflow", bus.overflow, 0);
        check_eq("rst late",     bus.late,     0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic write_entry(input int i, input logic en, input int x, input int y, input int gl);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 4'(i);
        bus.cfg_en    = en;
        bus.cfg_x     = 10'(x);
        bus.cfg_y     = 10'(y);
        bus.cfg_glyph = 4'(gl);
        step();
        bus.cfg_we    = 1'b0;
        if (i < NSPR) begin
            m_en[i] = en;
            m_x[i]  = x;
            m_y[i]  = y;
            m_g[i]  = gl;
        end
    endtask

    // Schedule line after vp; line_begin arrives g cycles after fetch_start
    task automatic run_line(input int vp, input int g);
        int         ty, nh, nn, scan_lim, addr;
        int         nx   [SLOTS];
        int         nid  [SLOTS];
        logic [7:0] nrow [SLOTS];
        logic [6:0] prev;
        ty       = (vp == V_LINES - 1) ? 0 : vp + 1;
        scan_lim = (g - 1 < NSPR - 1) ? g - 1 : NSPR - 1;
        nh = 0;
        nn = 0;
        for (int i = 0; i <= scan_lim; i++) begin
            if (m_en[i] && ty >= m_y[i] && ty < m_y[i] + SZ) begin
                nh++;
                if (nh <= SLOTS) begin
                    addr    = m_g[i] * 8 + ((ty - m_y[i]) >> SCALE_SHIFT);
                    exp_rom = 7'(addr);
                    // fetched byte lands two cycles after the entry is scanned
                    if (i <= g - 3) begin
                        nx[nn]   = m_x[i];
                        nid[nn]  = i;
                        nrow[nn] = rom[addr];
                        nn++;
                    end
                end
            end
        end
        if (nh > SLOTS) exp_ovf = 1'b1;
        if (g <= NSPR + 1) exp_late = 1'b1;

        prev    = bus.rom_addr;
        rom_chg = 0;
        bus.vpos        = 10'(vp);
        bus.fetch_start = 1'b1;
        step();
        bus.fetch_start = 1'b0;
        for (int k = 0; k < g; k++) begin
            if (k > 0) step();
            check_eq($sformatf("busy k=%0d", k), bus.busy, 32'(k <= NSPR));
            if (bus.rom_addr !== prev) rom_chg++;
            prev = bus.rom_addr;
        end
        bus.line_begin = 1'b1;
        step();
        bus.line_begin = 1'b0;
        check_eq("busy after line", bus.busy,     0);
        check_eq("late",            bus.late,     exp_late);
        check_eq("overflow",        bus.overflow, exp_ovf);
        check_eq("rom_addr held",   bus.rom_addr, exp_rom);
        f_n = nn;
        for (int s = 0; s < nn; s++) begin
            f_x[s]   = nx[s];
            f_id[s]  = nid[s];
            f_row[s] = nrow[s];
        end
    endtask

    task automatic probe(input int h, input logic on, input int id);
        bus.hpos = 10'(h);
        step();
        check_eq($sformatf("probe on h=%0d", h), bus.pixel_on, on);
        check_eq($sformatf("probe id h=%0d", h), bus.pixel_id, id);
    endtask

    task automatic sweep();
        logic       eo;
        logic [3:0] ei;
        for (int h = 0; h < 1024; h++) begin
            bus.hpos = 10'(h);
            step();
            exp_pix(h, eo, ei);
            check_eq($sformatf("pix_on h=%0d", h), bus.pixel_on, eo);
            check_eq($sformatf("pix_id h=%0d", h), bus.pixel_id, ei);
        end
    endtask

    initial begin
        int vp, ty, y, x, g;
        bus.hpos = '0;  bus.vpos = '0;  bus.fetch_start = 1'b0; bus.line_begin = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
        bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_glyph = '0;
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
        model_reset();

        // Single sprite, 2x magnified row byte
        do_reset();
        rom[16] = 8'hC3;
        write_entry(0, 1'b1, 64, 240, 2);
        run_line(239, 16);
        check_eq("single rom_addr", bus.rom_addr, 7'h10);
        probe(63, 1'b0, 0);
        probe(64, 1'b1, 0);
        probe(67, 1'b1, 0);
        probe(68, 1'b0, 0);
        probe(79, 1'b1, 0);
        probe(80, 1'b0, 0);
        sweep();

        // Overlap priority
        do_reset();
        rom[24] = 8'hF0;
        rom[32] = 8'hFF;
        write_entry(3, 1'b1, 100, 10, 3);
        write_entry(5, 1'b1, 100, 10, 4);
        run_line(9, 15);
        probe(100, 1'b1, 3);
        probe(107, 1'b1, 3);
        probe(108, 1'b1, 5);
        probe(115, 1'b1, 5);
        sweep();
        // line_begin while idle keeps the front buffer
        bus.line_begin = 1'b1;
        step();
        bus.line_begin = 1'b0;
        probe(104, 1'b1, 3);
        probe(110, 1'b1, 5);

        // Overflow: six hits, four slots
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rom[(i + 1) * 8] = 8'hFF;
            write_entry(i, 1'b1, 10 + 100 * i, 300, i + 1);
        end
        run_line(299, 16);
        check_eq("ovf rom issues", rom_chg, 4);
        for (int i = 0; i < 6; i++) probe(12 + 100 * i, i < 4, (i < 4) ? i : 0);
        sweep();

        // Frame wrap: ty=0, no 10-bit wrap of y=1014
        do_reset();
        rom[56] = 8'hFF;
        rom[64] = 8'hFF;
        write_entry(0, 1'b1, 200, 0, 7);
        write_entry(1, 1'b1, 300, 1014, 8);
        run_line(524, 16);
        probe(205, 1'b1, 0);
        probe(305, 1'b0, 0);
        sweep();

        // Late swap after 5 cycles
        do_reset();
        rom[72] = 8'hFF;
        rom[80] = 8'hFF;
        write_entry(1, 1'b1, 400, 51, 9);
        write_entry(7, 1'b1, 500, 51, 10);
        run_line(50, 5);
        check_eq("late flag", bus.late, 1);
        probe(405, 1'b1, 1);
        probe(505, 1'b0, 0);
        bus.line_begin = 1'b1;
        step();
        bus.line_begin = 1'b0;
        probe(405, 1'b1, 1);
        run_line(50, 16);
        probe(505, 1'b1, 7);

        // Reset in the middle of a scan
        do_reset();
        rom[88] = 8'hFF;
        write_entry(0, 1'b1, 600, 101, 11);
        bus.vpos = 10'd100;
        bus.fetch_start = 1'b1;
        step();
        bus.fetch_start = 1'b0;
        step();
        check_eq("busy mid scan", bus.busy, 1);
        rst_n = 1'b0;
        step();
        check_eq("rst mid busy", bus.busy, 0);
        check_eq("rst mid pix",  bus.pixel_on, 0);
        rst_n = 1'b1;
        model_reset();
        run_line(100, 16);
        probe(605, 1'b0, 0);
        write_entry(0, 1'b1, 600, 101, 11);
        run_line(100, 16);
        probe(605, 1'b1, 0);

        // Randomized tables against the model
        for (int t = 0; t < 24; t++) begin
            if (t % 6 == 0) do_reset();
            vp = $urandom_range(0, V_LINES - 1);
            ty = (vp == V_LINES - 1) ? 0 : vp + 1;
            for (int i = 0; i < NSPR; i++) begin
                if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 1023);
                else begin
                    y = ty - 18 + $urandom_range(0, 22);
                    if (y < 0) y = 0;
                    if (y > 1023) y = 1023;
                end
                x = ($urandom_range(0, 4) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 1023);
                write_entry(i, ($urandom_range(0, 4) != 0), x, y, $urandom_range(0, 15));
            end
            write_entry($urandom_range(NSPR, 15), 1'b1, $urandom_range(0, 1000), ty, 1);
            g = ($urandom_range(0, 9) < 7) ? $urandom_range(NSPR + 2, NSPR + 6)
                                            : $urandom_range(1, NSPR + 1);
            run_line(vp, g);
            sweep();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
